// File: rtl/d_ff_pipe.sv
// Shift-register pipeline with per-stage valid bits, a combinational tap, and a registered occupancy count.
// Priority at each rising edge: reset > set > flush > enable > hold.

module d_ff_pipe_stage #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_n,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= RST_VAL;
            q_vld <= 1'b0;
        end else if (!set_n) begin
            q     <= SET_VAL;
            q_vld <= 1'b0;
        end else if (flush) begin
            q_vld <= 1'b0;
        end else if (en) begin
            q     <= d;
            q_vld <= vld;
        end
    end
endmodule

module d_ff_pipe #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    localparam int              TW      = $clog2(DEPTH),
    localparam int              OW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_n,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    input  logic             vld_in,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] d_out,
    output logic             vld_out,
    output logic [WIDTH-1:0] tap_out,
    output logic             tap_vld,
    output logic [OW-1:0]    occ
);
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] sd;
        logic             sv;
        if (i == 0) begin : g_head
            assign sd = d_in;
            assign sv = vld_in;
        end else begin : g_body
            assign sd = data[i-1];
            assign sv = vld[i-1];
        end
        d_ff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .set_n (set_n),
            .flush (flush),
            .en    (en),
            .d     (sd),
            .vld   (sv),
            .q     (data[i]),
            .q_vld (vld[i])
        );
    end

    assign d_out   = data[DEPTH-1];
    assign vld_out = vld[DEPTH-1];

    // Out-of-range selects (non-power-of-2 DEPTH) fall through to the reset value.
    always_comb begin
        tap_out = RST_VAL;
        tap_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_out = data[i];
                tap_vld = vld[i];
            end
        end
    end

    // Occupancy tracks the entering and leaving valid bits, so it never needs a full popcount.
    always_ff @(posedge clk) begin
        if (!rst_n || !set_n || flush) begin
            occ <= '0;
        end else if (en) begin
            if (vld_in && !vld[DEPTH-1])
                occ <= occ + OW'(1);
            else if (!vld_in && vld[DEPTH-1])
                occ <= occ - OW'(1);
        end
    end
endmodule

// File: tb/tb_d_ff_pipe.sv
// Scoreboard bench for d_ff_pipe (WIDTH=3, DEPTH=4, RST_VAL=0, SET_VAL=7) with hand-computed directed vectors.

module tb_d_ff_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, set_n = 1'b1, flush = 1'b0, en = 1'b0, vld_in = 1'b0;
    logic [2:0] d_in = '0;
    logic [1:0] tap_sel = '0;
    logic [2:0] d_out, tap_out, occ;
    logic       vld_out, tap_vld;

    typedef struct {
        logic [2:0] d;
        logic       v;
        logic [2:0] o;
        logic [2:0] t;
        logic       tv;
        logic [4:0] m;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    d_ff_pipe #(.WIDTH(3), .DEPTH(4), .RST_VAL(3'd0), .SET_VAL(3'd7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_n   (set_n),
        .flush   (flush),
        .en      (en),
        .d_in    (d_in),
        .vld_in  (vld_in),
        .tap_sel (tap_sel),
        .d_out   (d_out),
        .vld_out (vld_out),
        .tap_out (tap_out),
        .tap_vld (tap_vld),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, want);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.m[4]) chk("d_out",   e.id, int'(d_out),   int'(e.d));
            if (e.m[3]) chk("vld_out", e.id, int'(vld_out), int'(e.v));
            if (e.m[2]) chk("occ",     e.id, int'(occ),     int'(e.o));
            if (e.m[1]) chk("tap_out", e.id, int'(tap_out), int'(e.t));
            if (e.m[0]) chk("tap_vld", e.id, int'(tap_vld), int'(e.tv));
        end
    end

    // Drive one edge's inputs and queue the state expected right after that edge.
    task automatic step(input logic r, input logic s, input logic f, input logic e, input logic vi,
                        input logic [2:0] di, input logic [1:0] sel,
                        input logic [2:0] xd, input logic xv, input logic [2:0] xo,
                        input logic [2:0] xt, input logic xtv, input logic [4:0] m);
        exp_t x;
        @(negedge clk);
        rst_n = r; set_n = s; flush = f; en = e; vld_in = vi; d_in = di; tap_sel = sel;
        step_id++;
        x.d = xd; x.v = xv; x.o = xo; x.t = xt; x.tv = xtv; x.m = m; x.id = step_id;
        sb.push_back(x);
    endtask

    localparam logic [4:0] ALL = 5'b11111;

    initial begin
        // Reset held two edges; en/vld_in asserted to show they are ignored.
        step(0,1,0,0,0,3'd0,2'd0, 0,0,0,0,0, 5'b00000);
        step(0,1,0,1,1,3'd5,2'd0, 0,0,0,0,0, ALL);

        // Fill 5,6,4,1
        step(1,1,0,1,1,3'd5,2'd0, 0,0,1,5,1, ALL);
        step(1,1,0,1,1,3'd6,2'd0, 0,0,2,6,1, ALL);
        step(1,1,0,1,1,3'd4,2'd0, 0,0,3,4,1, ALL);
        step(1,1,0,1,1,3'd1,2'd0, 5,1,4,1,1, ALL);
        // Hold with tap sweep; vld_in ignored
        step(1,1,0,0,0,3'd7,2'd3, 5,1,4,5,1, ALL);
        step(1,1,0,0,0,3'd7,2'd1, 5,1,4,4,1, ALL);
        step(1,1,0,0,1,3'd7,2'd2, 5,1,4,6,1, ALL);
        // Flush with en=1: valid cleared, data kept, no shift
        step(1,1,1,1,1,3'd3,2'd3, 5,0,0,5,0, ALL);
        step(1,1,0,0,0,3'd3,2'd0, 5,0,0,1,0, ALL);

        // Stall: 5,6 then 3 idle cycles then 4,1
        step(0,1,0,0,0,3'd0,2'd0, 0,0,0,0,0, ALL);
        step(1,1,0,1,1,3'd5,2'd0, 0,0,1,5,1, ALL);
        step(1,1,0,1,1,3'd6,2'd0, 0,0,2,6,1, ALL);
        step(1,1,0,0,1,3'd7,2'd0, 0,0,2,6,1, ALL);
        step(1,1,0,0,1,3'd7,2'd0, 0,0,2,6,1, ALL);
        step(1,1,0,0,1,3'd7,2'd0, 0,0,2,6,1, ALL);
        step(1,1,0,1,1,3'd4,2'd0, 0,0,3,4,1, ALL);
        step(1,1,0,1,1,3'd1,2'd0, 5,1,4,1,1, ALL);

        // Reset beats set; then set (with flush) loads SET_VAL, valid cleared
        step(0,0,0,1,1,3'd2,2'd2, 0,0,0,0,0, ALL);
        step(1,0,1,1,1,3'd2,2'd2, 7,0,0,7,0, ALL);

        // Bubbles: alternate vld_in with d_in=2
        step(0,1,0,0,0,3'd0,2'd0, 0,0,0,0,0, ALL);
        step(1,1,0,1,1,3'd2,2'd1, 0,0,1,0,0, ALL);
        step(1,1,0,1,0,3'd2,2'd1, 0,0,1,2,1, ALL);
        step(1,1,0,1,1,3'd2,2'd1, 0,0,2,2,0, ALL);
        step(1,1,0,1,0,3'd2,2'd1, 2,1,2,2,1, ALL);
        step(1,1,0,1,1,3'd2,2'd1, 2,0,2,2,0, ALL);
        step(1,1,0,1,0,3'd2,2'd1, 2,1,2,2,1, ALL);

        // Reset mid-stream, asserted alongside set/flush/en
        step(0,1,0,0,0,3'd0,2'd0, 0,0,0,0,0, ALL);
        step(1,1,0,1,1,3'd3,2'd0, 0,0,1,3,1, ALL);
        step(1,1,0,1,1,3'd2,2'd0, 0,0,2,2,1, ALL);
        step(1,1,0,1,1,3'd1,2'd0, 0,0,3,1,1, ALL);
        step(0,0,1,1,1,3'd7,2'd0, 0,0,0,0,0, ALL);
        step(1,1,0,1,1,3'd6,2'd0, 0,0,1,6,1, ALL);
        step(1,1,0,1,1,3'd5,2'd0, 0,0,2,5,1, ALL);
        step(1,1,0,1,1,3'd4,2'd0, 0,0,3,4,1, ALL);
        step(1,1,0,1,1,3'd3,2'd0, 6,1,4,3,1, ALL);
        // Full pipe keeps shifting valid words: occ saturates at DEPTH
        step(1,1,0,1,1,3'd2,2'd3, 5,1,4,5,1, ALL);
        step(1,1,0,1,0,3'd2,2'd0, 4,1,3,2,0, ALL);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/d_ff_pipe.md
D_FF_PIPE -- requirements
Module: d_ff_pipe

Interface
REQ-001 Parameter WIDTH, default 3, data width per stage in bits (legal 1..64).
REQ-002 Parameter DEPTH, default 4, number of register stages (legal 2..32).
REQ-003 Parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage by reset.
REQ-004 Parameter SET_VAL, default all-ones, WIDTH-bit value loaded into every data stage by set.
REQ-005 Port clk, input, 1, single clock; all state updates on rising edge only.
REQ-006 Port rst_n, input, 1, reset, synchronous, active-low.
REQ-007 Port set_n, input, 1, synchronous active-low preset of all data stages.
REQ-008 Port flush, input, 1, synchronous active-high; clears all valid bits, data retained.
REQ-009 Port en, input, 1, clock enable for the shift operation.
REQ-010 Port d_in, input, WIDTH, data entering stage 0.
REQ-011 Port vld_in, input, 1, qualifier for d_in.
REQ-012 Port tap_sel, input, $clog2(DEPTH), selects stage driven onto tap_out.
REQ-013 Port d_out, output, WIDTH, registered content of stage DEPTH-1.
REQ-014 Port vld_out, output, 1, valid bit of stage DEPTH-1.
REQ-015 Port tap_out, output, WIDTH, content of stage tap_sel (combinational mux of registers).
REQ-016 Port tap_vld, output, 1, valid bit of stage tap_sel.
REQ-017 Port occ, output, $clog2(DEPTH+1), count of stages whose valid bit is 1.

Function
REQ-018 Per rising edge, action priority SHALL be: rst_n=0 > set_n=0 > flush=1 > en=1 > hold.
REQ-019 Shift (en=1, no higher-priority event): stage0 <= {d_in, vld_in}; stage i <= stage i-1 for i=1..DEPTH-1; old stage DEPTH-1 discarded.
REQ-020 Hold (en=0, no other event): all data and valid bits unchanged; vld_in ignored.
REQ-021 Latency: with en held 1, d_in/vld_in sampled at edge k appear on d_out/vld_out after edge k+DEPTH-1 (DEPTH edges total through the chain, first edge loads stage0).
REQ-022 Each idle (en=0) cycle adds exactly one cycle of latency to all in-flight words; no word is dropped or duplicated.
REQ-023 vld_in=0 with en=1 SHALL shift a bubble: data bits still shift, valid bit 0.
REQ-024 set_n=0: every data stage <= SET_VAL, every valid bit <= 0; en and d_in ignored that cycle.
REQ-025 flush=1: every valid bit <= 0, data stages unchanged, no shift even if en=1.
REQ-026 tap_out/tap_vld SHALL follow tap_sel combinationally from stage registers, no added latency.
REQ-027 tap_sel >= DEPTH (non-power-of-2 DEPTH): tap_out SHALL be RST_VAL and tap_vld SHALL be 0.
REQ-028 occ SHALL be registered, equal to popcount of valid bits after each edge, range 0..DEPTH, never wraps.
REQ-029 occ update on shift: +1 if vld_in=1 and old stage DEPTH-1 invalid; -1 if vld_in=0 and old stage DEPTH-1 valid; else unchanged.
REQ-030 Simultaneous set_n=0 and flush=1: set behaviour only (valid bits cleared either way, data = SET_VAL).

Reset
REQ-031 rst_n=0 at a rising edge: all data stages <= RST_VAL, all valid bits <= 0, occ <= 0; d_out=RST_VAL, vld_out=0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight words at that edge regardless of set_n, flush, en.
REQ-033 rst_n deassertion between edges SHALL have no effect until the next rising edge; no asynchronous path from rst_n to any register.
REQ-034 Before the first edge with rst_n=0, outputs are undefined; bench SHALL hold rst_n=0 for at least 2 edges.

Verification (WIDTH=3, DEPTH=4, RST_VAL=0, SET_VAL=7)
REQ-035 Fill: reset, then en=1, vld_in=1, d_in=5,6,4,1 on 4 edges -> after 4th edge d_out=5, vld_out=1, occ=4; tap_sel=0 gives tap_out=1.
REQ-036 Stall: mid-fill drop en for 3 cycles -> d_out/occ frozen, first word reaches d_out exactly 3 edges later than REQ-035.
REQ-037 Set priority: rst_n=0 and set_n=0 same edge -> all stages 0, occ=0; next edge rst_n=1, set_n=0 -> d_out=7, vld_out=0, occ=0.
REQ-038 Flush: full pipe of 5,6,4,1, flush=1 with en=1 -> occ=0, vld_out=0, d_out still 5, tap_out(sel=3)=5.
REQ-039 Bubbles: alternate vld_in=1/0 with d_in=2 continuous en -> occ settles at 2, vld_out toggles each cycle from edge 4.
REQ-040 Reset mid-stream: occ=3 then rst_n=0 for one edge -> d_out=0, occ=0; refill resumes with REQ-021 latency.
